// File: rtl/ofdm_symbol_sync_mw.sv
// rtl/ofdm_symbol_sync_mw.sv - OFDM symbol synchroniser: block-average onset detect, CP strip, symbol packets
// Ports:
//   clock_clk, reset_reset        clock and asynchronous active-high reset
//   asi_in0_data/valid            {real, imag} signed samples, no backpressure
//   cfg_threshold, cfg_enable     live detection threshold and enable
//   aso_out0_data/valid/sop/eop   forwarded symbol samples, one packet per symbol
//   pre_sampling                  1 while searching or in holdoff
//   sync_pulse                    one-cycle pulse after the detecting sample
//   symbol_count                  completed symbols, wrapping
module ofdm_symbol_sync_mw #(
    parameter int DATA_W            = 16,
    parameter int LONG_LOG2         = 5,
    parameter int SHORT_LOG2        = 1,
    parameter int SYMBOL_LEN        = 64,
    parameter int CP_LEN            = 16,
    parameter int SYMBOLS_PER_FRAME = 1,
    parameter int HOLDOFF           = 512,
    parameter int NEGATE            = 1
) (
    input  logic                clock_clk,
    input  logic                reset_reset,
    input  logic [2*DATA_W-1:0] asi_in0_data,
    input  logic                asi_in0_valid,
    input  logic [DATA_W:0]     cfg_threshold,
    input  logic                cfg_enable,
    output logic [2*DATA_W-1:0] aso_out0_data,
    output logic                aso_out0_valid,
    output logic                aso_out0_startofpacket,
    output logic                aso_out0_endofpacket,
    output logic                pre_sampling,
    output logic                sync_pulse,
    output logic [15:0]         symbol_count
);
    localparam int ACC_W   = DATA_W + LONG_LOG2;
    localparam int CNT_MAX = (SYMBOL_LEN > CP_LEN)
                           ? ((SYMBOL_LEN > HOLDOFF) ? SYMBOL_LEN : HOLDOFF)
                           : ((CP_LEN > HOLDOFF) ? CP_LEN : HOLDOFF);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SD_W    = (SYMBOLS_PER_FRAME > 1) ? $clog2(SYMBOLS_PER_FRAME) : 1;
    // Short windows are aligned sub-blocks of the long window, so the short
    // window position is just the low SHORT_LOG2 bits of the long counter.
    localparam logic [LONG_LOG2-1:0] SHORT_MASK = LONG_LOG2'((1 << SHORT_LOG2) - 1);
    localparam logic [DATA_W-1:0]    MIN_VAL    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]    MAX_VAL    = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {S_SEARCH, S_CP_SKIP, S_PAYLOAD, S_HOLDOFF} state_t;

    function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
        if (x == MIN_VAL) return MAX_VAL;
        return -x;
    endfunction

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [SD_W-1:0]           r_sym_done;
    logic [LONG_LOG2-1:0]      r_lcnt;
    logic                      r_settled;
    logic signed [ACC_W-1:0]   r_lacc [2];
    logic signed [ACC_W-1:0]   r_sacc [2];
    logic [DATA_W-1:0]         r_lavg [2];
    logic [2*DATA_W-1:0]       r_out_data;
    logic                      r_out_valid, r_out_sop, r_out_eop, r_pre, r_sync;
    logic [15:0]               r_sym_count;

    logic [DATA_W-1:0]         w_sample [2];
    logic signed [ACC_W-1:0]   w_lsum [2];
    logic signed [ACC_W-1:0]   w_ssum [2];
    logic [DATA_W-1:0]         w_savg [2];
    logic [DATA_W:0]           w_diff [2];
    logic [DATA_W:0]           w_abs  [2];
    logic                      w_long_done, w_short_done, w_detect;
    logic [2*DATA_W-1:0]       w_out;

    always_comb begin
        w_sample[0]  = asi_in0_data[2*DATA_W-1:DATA_W];
        w_sample[1]  = asi_in0_data[DATA_W-1:0];
        w_long_done  = &r_lcnt;
        w_short_done = (r_lcnt & SHORT_MASK) == SHORT_MASK;
        w_detect     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            w_lsum[c] = r_lacc[c] + {{LONG_LOG2{w_sample[c][DATA_W-1]}}, w_sample[c]};
            w_ssum[c] = r_sacc[c] + {{LONG_LOG2{w_sample[c][DATA_W-1]}}, w_sample[c]};
            // Arithmetic shift then truncate == taking the bit slice above the shift.
            w_savg[c] = w_ssum[c][SHORT_LOG2 +: DATA_W];
            w_diff[c] = {r_lavg[c][DATA_W-1], r_lavg[c]} - {w_savg[c][DATA_W-1], w_savg[c]};
            w_abs[c]  = w_diff[c][DATA_W] ? -w_diff[c] : w_diff[c];
            if (w_abs[c] > cfg_threshold) w_detect = 1'b1;
        end
        w_detect = w_detect && (r_state == S_SEARCH) && asi_in0_valid && w_short_done
                   && cfg_enable && r_settled;
        w_out = (NEGATE != 0) ? {sat_neg(w_sample[0]), sat_neg(w_sample[1])} : asi_in0_data;
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= S_SEARCH;
            r_cnt       <= '0;
            r_sym_done  <= '0;
            r_lcnt      <= '0;
            r_settled   <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                r_lacc[c] <= '0;
                r_sacc[c] <= '0;
                r_lavg[c] <= '0;
            end
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_pre       <= 1'b1;
            r_sync      <= 1'b0;
            r_sym_count <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_sync      <= 1'b0;
            case (r_state)
                S_SEARCH: if (asi_in0_valid) begin
                    if (w_detect) begin
                        // Search state is cleared here and stays cleared until
                        // the next return to SEARCH.
                        r_sync    <= 1'b1;
                        r_pre     <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= (CP_LEN == 0) ? S_PAYLOAD : S_CP_SKIP;
                        r_lcnt    <= '0;
                        r_settled <= 1'b0;
                        for (int c = 0; c < 2; c++) begin
                            r_lacc[c] <= '0;
                            r_sacc[c] <= '0;
                            r_lavg[c] <= '0;
                        end
                    end else begin
                        r_lcnt <= r_lcnt + LONG_LOG2'(1);
                        if (w_long_done) r_settled <= 1'b1;
                        for (int c = 0; c < 2; c++) begin
                            if (w_long_done) begin
                                r_lacc[c] <= '0;
                                r_lavg[c] <= w_lsum[c][LONG_LOG2 +: DATA_W];
                            end else begin
                                r_lacc[c] <= w_lsum[c];
                            end
                            r_sacc[c] <= w_short_done ? '0 : w_ssum[c];
                        end
                    end
                end
                S_CP_SKIP: if (asi_in0_valid) begin
                    if (r_cnt == CNT_W'(CP_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_PAYLOAD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PAYLOAD: if (asi_in0_valid) begin
                    r_out_data  <= w_out;
                    r_out_valid <= 1'b1;
                    r_out_sop   <= (r_cnt == '0);
                    r_cnt       <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(SYMBOL_LEN - 1)) begin
                        r_out_eop   <= 1'b1;
                        r_sym_count <= r_sym_count + 16'd1;
                        r_cnt       <= '0;
                        if (r_sym_done == SD_W'(SYMBOLS_PER_FRAME - 1)) begin
                            r_sym_done <= '0;
                            r_pre      <= 1'b1;
                            r_state    <= (HOLDOFF == 0) ? S_SEARCH : S_HOLDOFF;
                        end else begin
                            r_sym_done <= r_sym_done + SD_W'(1);
                            r_state    <= (CP_LEN == 0) ? S_PAYLOAD : S_CP_SKIP;
                        end
                    end
                end
                S_HOLDOFF: begin
                    // Counts clocks, not samples: the front end settles in time.
                    if (r_cnt == CNT_W'(HOLDOFF - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_SEARCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_SEARCH;
            endcase
        end
    end

    assign aso_out0_data          = r_out_data;
    assign aso_out0_valid         = r_out_valid;
    assign aso_out0_startofpacket = r_out_sop;
    assign aso_out0_endofpacket   = r_out_eop;
    assign pre_sampling           = r_pre;
    assign sync_pulse             = r_sync;
    assign symbol_count           = r_sym_count;
endmodule

// File: tb/tb_ofdm_symbol_sync_mw.sv
// tb/tb_ofdm_symbol_sync_mw.sv - directed self-checking bench for ofdm_symbol_sync_mw
module tb_ofdm_symbol_sync_mw;
    localparam int BIG = 1 << 30;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      din = '0;
    logic             vld = 1'b0;
    logic [16:0]      thr = '0;
    logic             en  = 1'b0;
    logic [1:0][31:0] o_data;
    logic [1:0]       o_valid, o_sop, o_eop, o_pre, o_sync;
    logic [1:0][15:0] o_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Piecewise-constant stimulus: value v0 before k1, v1 before k2, v2 before k3, else v3.
    int rk1, rk2, rk3, rv0, rv1, rv2, rv3;
    int ik1, ik2, ik3, iv0, iv1, iv2, iv3;
    int en_base, en_off_k;
    logic [15:0] cur_re, cur_im;

    int nsync[2], det_a[2], det_b[2], nval[2], sop_a[2], sop_b[2];
    int eop_a[2], eop_b[2], nbad[2], npre0[2];
    logic [31:0] sop_data[2];

    always #5 clk = ~clk;

    ofdm_symbol_sync_mw dut0 (
        .clock_clk(clk), .reset_reset(rst), .asi_in0_data(din), .asi_in0_valid(vld),
        .cfg_threshold(thr), .cfg_enable(en),
        .aso_out0_data(o_data[0]), .aso_out0_valid(o_valid[0]),
        .aso_out0_startofpacket(o_sop[0]), .aso_out0_endofpacket(o_eop[0]),
        .pre_sampling(o_pre[0]), .sync_pulse(o_sync[0]), .symbol_count(o_cnt[0])
    );

    ofdm_symbol_sync_mw #(.SYMBOLS_PER_FRAME(2)) dut2 (
        .clock_clk(clk), .reset_reset(rst), .asi_in0_data(din), .asi_in0_valid(vld),
        .cfg_threshold(thr), .cfg_enable(en),
        .aso_out0_data(o_data[1]), .aso_out0_valid(o_valid[1]),
        .aso_out0_startofpacket(o_sop[1]), .aso_out0_endofpacket(o_eop[1]),
        .pre_sampling(o_pre[1]), .sync_pulse(o_sync[1]), .symbol_count(o_cnt[1])
    );

    function automatic logic [15:0] lvl(input int k, input int k1, input int k2, input int k3,
                                        input int v0, input int v1, input int v2, input int v3);
        if (k < k1) return 16'(v0);
        if (k < k2) return 16'(v1);
        if (k < k3) return 16'(v2);
        return 16'(v3);
    endfunction

    function automatic logic [15:0] neg16(input logic [15:0] x);
        if (x == 16'h8000) return 16'h7FFF;
        return 16'h0000 - x;
    endfunction

    task automatic set_re(input int v0, input int k1, input int v1, input int k2,
                          input int v2, input int k3, input int v3);
        rv0 = v0; rk1 = k1; rv1 = v1; rk2 = k2; rv2 = v2; rk3 = k3; rv3 = v3;
    endtask

    task automatic set_im(input int v0, input int k1, input int v1);
        iv0 = v0; ik1 = k1; iv1 = v1; ik2 = BIG; iv2 = v1; ik3 = BIG; iv3 = v1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        en_off_k = BIG;
    endtask

    task automatic observe(input int k);
        for (int d = 0; d < 2; d++) begin
            if (o_sync[d]) begin
                nsync[d]++;
                if (det_a[d] < 0) det_a[d] = k; else if (det_b[d] < 0) det_b[d] = k;
            end
            if (o_valid[d]) begin
                nval[d]++;
                if (o_data[d] !== {neg16(cur_re), neg16(cur_im)}) nbad[d]++;
            end
            if (o_sop[d]) begin
                if (sop_a[d] < 0) begin sop_a[d] = k; sop_data[d] = o_data[d]; end
                else if (sop_b[d] < 0) sop_b[d] = k;
            end
            if (o_eop[d]) begin
                if (eop_a[d] < 0) eop_a[d] = k; else if (eop_b[d] < 0) eop_b[d] = k;
            end
            if (!o_pre[d]) npre0[d]++;
        end
    endtask

    // Sends n samples, one per clock or (alt) with an idle cycle after each.
    task automatic run(input int n, input bit alt);
        for (int d = 0; d < 2; d++) begin
            nsync[d] = 0; det_a[d] = -1; det_b[d] = -1; nval[d] = 0; sop_a[d] = -1;
            sop_b[d] = -1; eop_a[d] = -1; eop_b[d] = -1; nbad[d] = 0; npre0[d] = 0;
            sop_data[d] = '0;
        end
        for (int k = 0; k < n; k++) begin
            cur_re = lvl(k, rk1, rk2, rk3, rv0, rv1, rv2, rv3);
            cur_im = lvl(k, ik1, ik2, ik3, iv0, iv1, iv2, iv3);
            din = {cur_re, cur_im};
            vld = 1'b1;
            en  = (k < en_off_k) ? en_base[0] : 1'b0;
            @(posedge clk); #1;
            observe(k);
            if (alt) begin
                vld = 1'b0;
                @(posedge clk); #1;
                observe(k);
            end
        end
        vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({o_valid[0], o_sop[0], o_eop[0], o_sync[0], o_pre[0]} !== 5'b00001) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 00001",
                                 {o_valid[0], o_sop[0], o_eop[0], o_sync[0], o_pre[0]});
        end
        n_checks++;
        if (o_data[0] !== 32'd0) begin
            n_errors++; $display("FAIL reset_data: got %h expected 0", o_data[0]);
        end
        n_checks++;
        if (o_cnt[0] !== 16'd0) begin
            n_errors++; $display("FAIL reset_count: got %0d expected 0", o_cnt[0]);
        end
    endtask

    task automatic test_no_detect();
        do_reset(); thr = 17'd50; en_base = 1;
        set_re(100, BIG, 100, BIG, 100, BIG, 100); set_im(100, BIG, 100);
        run(1000, 1'b0);
        n_checks++;
        if (nsync[0] !== 0) begin n_errors++; $display("FAIL const_sync: got %0d expected 0", nsync[0]); end
        n_checks++;
        if (nval[0] !== 0) begin n_errors++; $display("FAIL const_valid: got %0d expected 0", nval[0]); end
        n_checks++;
        if (npre0[0] !== 0) begin n_errors++; $display("FAIL const_pre: got %0d expected 0", npre0[0]); end
    endtask

    task automatic test_step();
        do_reset(); thr = 17'd50; en_base = 1; en_off_k = 70;
        set_re(0, 64, 1000, BIG, 1000, BIG, 1000); set_im(0, BIG, 0);
        run(260, 1'b0);
        n_checks++;
        if (det_a[0] !== 65) begin n_errors++; $display("FAIL step_det: got %0d expected 65", det_a[0]); end
        n_checks++;
        if (nsync[0] !== 1) begin n_errors++; $display("FAIL step_nsync: got %0d expected 1", nsync[0]); end
        n_checks++;
        if (sop_a[0] !== 82 || eop_a[0] !== 145) begin
            n_errors++; $display("FAIL step_sop_eop: got %0d/%0d expected 82/145", sop_a[0], eop_a[0]);
        end
        n_checks++;
        if (nval[0] !== 64) begin n_errors++; $display("FAIL step_nval: got %0d expected 64", nval[0]); end
        n_checks++;
        if (nbad[0] !== 0 || sop_data[0] !== {16'hFC18, 16'h0000}) begin
            n_errors++; $display("FAIL step_data: got %0d bad, sop %h expected 0 bad, fc180000", nbad[0], sop_data[0]);
        end
        n_checks++;
        if (o_cnt[0] !== 16'd1) begin n_errors++; $display("FAIL step_count: got %0d expected 1", o_cnt[0]); end
        n_checks++;
        if (npre0[0] !== 80) begin n_errors++; $display("FAIL step_pre: got %0d expected 80", npre0[0]); end
        n_checks++;
        if (sop_b[1] !== 162 || eop_b[1] !== 225) begin
            n_errors++; $display("FAIL frame2_sop_eop: got %0d/%0d expected 162/225", sop_b[1], eop_b[1]);
        end
        n_checks++;
        if (nval[1] !== 128 || nbad[1] !== 0) begin
            n_errors++; $display("FAIL frame2_nval: got %0d (%0d bad) expected 128 (0 bad)", nval[1], nbad[1]);
        end
        n_checks++;
        if (o_cnt[1] !== 16'd2) begin n_errors++; $display("FAIL frame2_count: got %0d expected 2", o_cnt[1]); end
        n_checks++;
        if (npre0[1] !== 160) begin n_errors++; $display("FAIL frame2_pre: got %0d expected 160", npre0[1]); end
    endtask

    task automatic test_enable();
        do_reset(); thr = 17'd50; en_base = 0;
        set_re(0, 64, 1000, BIG, 1000, BIG, 1000); set_im(0, BIG, 0);
        run(260, 1'b0);
        n_checks++;
        if (nsync[0] !== 0 || nval[0] !== 0) begin
            n_errors++; $display("FAIL disabled: got %0d syncs %0d outputs expected 0/0", nsync[0], nval[0]);
        end
    endtask

    task automatic test_threshold();
        do_reset(); thr = 17'd200; en_base = 1;
        set_re(0, BIG, 0, BIG, 0, BIG, 0); set_im(0, 64, 200);
        run(150, 1'b0);
        n_checks++;
        if (nsync[0] !== 0) begin n_errors++; $display("FAIL thr_equal: got %0d syncs expected 0", nsync[0]); end
        do_reset(); thr = 17'd199; en_base = 1;
        run(150, 1'b0);
        n_checks++;
        if (det_a[0] !== 65) begin n_errors++; $display("FAIL thr_above: got %0d expected 65", det_a[0]); end
        n_checks++;
        if (nval[0] !== 64 || nbad[0] !== 0) begin
            n_errors++; $display("FAIL thr_data: got %0d (%0d bad) expected 64 (0 bad)", nval[0], nbad[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset(); thr = 17'd50; en_base = 1;
        set_re(0, 64, -32768, BIG, -32768, BIG, -32768); set_im(0, BIG, 0);
        run(150, 1'b0);
        n_checks++;
        if (det_a[0] !== 65) begin n_errors++; $display("FAIL sat_det: got %0d expected 65", det_a[0]); end
        n_checks++;
        if (sop_data[0] !== {16'h7FFF, 16'h0000} || nbad[0] !== 0) begin
            n_errors++; $display("FAIL sat_data: got %h (%0d bad) expected 7fff0000", sop_data[0], nbad[0]);
        end
    endtask

    task automatic test_holdoff();
        do_reset(); thr = 17'd50; en_base = 1;
        set_re(0, 64, 1000, 400, 3000, 690, 0); set_im(0, BIG, 0);
        run(800, 1'b0);
        n_checks++;
        if (det_a[0] !== 65 || det_b[0] !== 691) begin
            n_errors++; $display("FAIL holdoff_det: got %0d/%0d expected 65/691", det_a[0], det_b[0]);
        end
        n_checks++;
        if (nsync[0] !== 2) begin n_errors++; $display("FAIL holdoff_nsync: got %0d expected 2", nsync[0]); end
        n_checks++;
        if (nsync[1] !== 1) begin n_errors++; $display("FAIL holdoff_frame2: got %0d expected 1", nsync[1]); end
    endtask

    task automatic test_gaps();
        do_reset(); thr = 17'd50; en_base = 1;
        set_re(0, 64, 1000, BIG, 1000, BIG, 1000); set_im(0, BIG, 0);
        run(260, 1'b1);
        n_checks++;
        if (det_a[0] !== 65 || sop_a[0] !== 82 || eop_a[0] !== 145) begin
            n_errors++; $display("FAIL gaps_pos: got %0d/%0d/%0d expected 65/82/145", det_a[0], sop_a[0], eop_a[0]);
        end
        n_checks++;
        if (nval[0] !== 64 || nbad[0] !== 0) begin
            n_errors++; $display("FAIL gaps_nval: got %0d (%0d bad) expected 64 (0 bad)", nval[0], nbad[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); thr = 17'd50; en_base = 1;
        set_re(0, 64, 1000, BIG, 1000, BIG, 1000); set_im(0, BIG, 0);
        run(100, 1'b0);
        n_checks++;
        if (o_valid[0] !== 1'b1 || o_pre[0] !== 1'b0) begin
            n_errors++; $display("FAIL mid_payload: got valid %b pre %b expected 1/0", o_valid[0], o_pre[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_valid[0], o_sop[0], o_eop[0], o_sync[0], o_pre[0]} !== 5'b00001 || o_data[0] !== 32'd0) begin
            n_errors++; $display("FAIL async_reset: got %b data %h expected 00001 data 0",
                                 {o_valid[0], o_sop[0], o_eop[0], o_sync[0], o_pre[0]}, o_data[0]);
        end
        n_checks++;
        if (o_cnt[1] !== 16'd0) begin n_errors++; $display("FAIL async_count: got %0d expected 0", o_cnt[1]); end
        @(posedge clk); #1 rst = 1'b0;
        set_re(1000, 32, 0, BIG, 0, BIG, 0);
        run(60, 1'b0);
        n_checks++;
        if (det_a[0] !== 33) begin n_errors++; $display("FAIL fresh_window: got %0d expected 33", det_a[0]); end
    endtask

    initial begin
        en_off_k = BIG; en_base = 0;
        set_re(0, BIG, 0, BIG, 0, BIG, 0); set_im(0, BIG, 0);
        cur_re = '0; cur_im = '0;
        test_reset();
        test_no_detect();
        test_step();
        test_enable();
        test_threshold();
        test_saturation();
        test_holdoff();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
